// File: rtl/mdu_pkg.sv
// Shared types and constants for the
// iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP
    } md_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute/Decode-side bundle for the
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hiloreadD;
    logic             mdstartD;
    logic             stallmd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE,
        output hiloreadD, mdstartD,
        input  stallmd, busy, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE,
        input  hiloreadD, mdstartD,
        output stallmd, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One shift-add multiply or restoring
// divide iteration on the {hi,lo} pair.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Mul: add-if-LSB then shift right; div: shift left, trial subtract.
    always_comb begin
        w_sum = {1'b0, i_hi}
              + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_shl = {i_hi, i_lo[WIDTH-1]};
        w_ge  = (w_shl >= {1'b0, i_opnd});
        w_sub = w_shl[WIDTH-1:0] - i_opnd;
        o_hi  = w_sum[WIDTH:1];
        o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_div) begin
            if (w_ge) begin
                o_hi = w_sub;
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shl[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with
// HI/LO registers beside the Execute ALU.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave md
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        r_state;
    md_state_e        w_next;
    logic             r_isdiv;
    logic             r_sa;
    logic             r_sb;
    logic             r_dvz;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    md_op_e           w_op;
    logic             w_div_in;
    logic             w_dvz_in;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Operand decode: signed ops take magnitudes of negative inputs.
    always_comb begin
        w_op     = md_op_e'(md.opE);
        w_div_in = op_is_div(w_op);
        w_dvz_in = w_div_in && (md.srcbE == '0);
        w_a_neg  = op_is_signed(w_op) && md.srcaE[WIDTH-1];
        w_b_neg  = op_is_signed(w_op) && md.srcbE[WIDTH-1];
        w_a_mag  = w_a_neg ? -md.srcaE : md.srcaE;
        w_b_mag  = w_b_neg ? -md.srcbE : md.srcbE;
        w_last   = (r_cnt == CW'(WIDTH - 1));
    end

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div  (r_isdiv),
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_step_hi),
        .o_lo   (w_step_lo)
    );

    // Sign/zero fixup of the finished magnitude result.
    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_quot   = (r_sa ^ r_sb) ? -r_acc_lo : r_acc_lo;
        w_rem    = r_sa ? -r_acc_hi : r_acc_hi;
        if (r_sa ^ r_sb) begin
            w_prod = -w_prod;
        end
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_dvz) begin
            w_fix_hi = r_acc_hi;
            w_fix_lo = '1;
        end else if (r_isdiv) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    // Next-state selection for the sequencer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (md.startE) begin
                    if (!w_div_in) begin
                        w_next = MUL;
                    end else if (w_dvz_in) begin
                        w_next = FIXUP;
                    end else begin
                        w_next = DIV;
                    end
                end
            end
            MUL:     if (w_last) w_next = FIXUP;
            DIV:     if (w_last) w_next = FIXUP;
            FIXUP:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latch, iteration datapath and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isdiv  <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dvz    <= 1'b0;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FIXUP);
            unique case (r_state)
                IDLE: begin
                    if (md.startE) begin
                        r_isdiv <= w_div_in;
                        r_sa    <= w_a_neg;
                        r_sb    <= w_b_neg;
                        r_dvz   <= w_dvz_in;
                        r_cnt   <= '0;
                        if (w_div_in) begin
                            r_acc_hi <= w_dvz_in ? md.srcaE : '0;
                            r_acc_lo <= w_a_mag;
                            r_opnd   <= w_b_mag;
                        end else begin
                            r_acc_hi <= '0;
                            r_acc_lo <= w_b_mag;
                            r_opnd   <= w_a_mag;
                        end
                    end
                end
                MUL, DIV: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + 1'b1;
                end
                FIXUP: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    // Status and stall outputs.
    always_comb begin
        md.busy    = (r_state != IDLE);
        md.stallmd = md.busy && (md.hiloreadD || md.mdstartD);
        md.done    = r_done;
        md.hi      = r_hi;
        md.lo      = r_lo;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit
// with hand-computed HI/LO results.
module tb_muldiv_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    localparam logic [1:0]   DV_OP [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
    localparam logic [W-1:0] DV_A  [5] = '{32'hFFFFFFF9, 32'h00000007, 32'd100,
                                          32'h80000000, 32'hFFFFFFFF};
    localparam logic [W-1:0] DV_B  [5] = '{32'h00000002, 32'hFFFFFFFE, 32'd7,
                                          32'hFFFFFFFF, 32'h00000001};
    localparam logic [W-1:0] DV_HI [5] = '{32'hFFFFFFFF, 32'h00000001, 32'd2,
                                          32'h00000000, 32'h00000000};
    localparam logic [W-1:0] DV_LO [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd14,
                                          32'h80000000, 32'hFFFFFFFF};

    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    muldiv_unit_if #(.WIDTH(W)) mif ();

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mif.startE && mif.busy))
                else $error("FAIL start_while_busy startE=1 busy=1 required busy=0");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int ncyc,
                         output logic dn, output logic early,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        mif.startE = 1'b1;
        mif.opE    = op;
        mif.srcaE  = a;
        mif.srcbE  = b;
        @(negedge clk);
        mif.startE = 1'b0;
        ncyc  = 0;
        early = 1'b0;
        while (mif.busy && ncyc < 100) begin
            ncyc++;
            if (mif.done) early = 1'b1;
            @(negedge clk);
        end
        dn = mif.done;
        h  = mif.hi;
        l  = mif.lo;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vecs++;
        if (mif.busy !== 1'b0) begin
            errs++; $display("FAIL rst_busy got %b want 0", mif.busy);
        end
        vecs++;
        if (mif.done !== 1'b0) begin
            errs++; $display("FAIL rst_done got %b want 0", mif.done);
        end
        vecs++;
        if (mif.hi !== '0) begin
            errs++; $display("FAIL rst_hi got %h want 0", mif.hi);
        end
        vecs++;
        if (mif.lo !== '0) begin
            errs++; $display("FAIL rst_lo got %h want 0", mif.lo);
        end
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if (mif.stallmd !== 1'b0) begin
            errs++; $display("FAIL idle_stall got %b want 0", mif.stallmd);
        end
        mif.hiloreadD = 1'b0;
        mif.mdstartD  = 1'b0;
    endtask

    task automatic test_mult;
        int n; logic dn, early; logic [W-1:0] h, l;
        do_op(MD_MULT, 32'h00000007, 32'hFFFFFFFD, n, dn, early, h, l);
        vecs++;
        if (n != 33) begin
            errs++; $display("FAIL mult_busy got %0d want 33", n);
        end
        vecs++;
        if (dn !== 1'b1 || early !== 1'b0) begin
            errs++; $display("FAIL mult_done got %b/%b want 1/0", dn, early);
        end
        vecs++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin
            errs++; $display("FAIL mult_hilo got %h_%h want ffffffff_ffffffeb", h, l);
        end
        @(negedge clk);
        vecs++;
        if (mif.done !== 1'b0 || mif.lo !== 32'hFFFFFFEB) begin
            errs++; $display("FAIL mult_after got done=%b lo=%h want 0 ffffffeb",
                             mif.done, mif.lo);
        end
    endtask

    task automatic test_mult_extremes;
        int n; logic dn, early; logic [W-1:0] h, l;
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, dn, early, h, l);
        vecs++;
        if (h !== 32'hFFFFFFFE || l !== 32'h00000001 || dn !== 1'b1) begin
            errs++; $display("FAIL multu_max got %h_%h done=%b want fffffffe_00000001 1",
                             h, l, dn);
        end
        do_op(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, n, dn, early, h, l);
        vecs++;
        if (n != 33 || early !== 1'b0) begin
            errs++; $display("FAIL b2b_busy got %0d early=%b want 33 0", n, early);
        end
        vecs++;
        if (h !== 32'h0 || l !== 32'h1 || dn !== 1'b1) begin
            errs++; $display("FAIL mult_m1 got %h_%h done=%b want 00000000_00000001 1",
                             h, l, dn);
        end
    endtask

    task automatic test_div;
        int n; logic dn, early; logic [W-1:0] h, l;
        for (int i = 0; i < 5; i++) begin
            do_op(DV_OP[i], DV_A[i], DV_B[i], n, dn, early, h, l);
            vecs++;
            if (n != 33 || dn !== 1'b1) begin
                errs++; $display("FAIL div%0d_busy got %0d done=%b want 33 1", i, n, dn);
            end
            vecs++;
            if (h !== DV_HI[i] || l !== DV_LO[i]) begin
                errs++; $display("FAIL div%0d_hilo got %h_%h want %h_%h",
                                 i, h, l, DV_HI[i], DV_LO[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int n; logic dn, early; logic [W-1:0] h, l;
        do_op(MD_DIVU, 32'd5, 32'd0, n, dn, early, h, l);
        vecs++;
        if (n != 1 || dn !== 1'b1) begin
            errs++; $display("FAIL divu0_busy got %0d done=%b want 1 1", n, dn);
        end
        vecs++;
        if (h !== 32'd5 || l !== 32'hFFFFFFFF) begin
            errs++; $display("FAIL divu0_hilo got %h_%h want 00000005_ffffffff", h, l);
        end
        do_op(MD_DIV, 32'hFFFFFFFB, 32'd0, n, dn, early, h, l);
        vecs++;
        if (n != 1 || h !== 32'hFFFFFFFB || l !== 32'hFFFFFFFF) begin
            errs++; $display("FAIL div0_neg got %0d %h_%h want 1 fffffffb_ffffffff",
                             n, h, l);
        end
    endtask

    task automatic test_stall;
        int n, bad;
        for (int s = 0; s < 2; s++) begin
            mif.startE = 1'b1;
            mif.opE    = MD_MULTU;
            mif.srcaE  = 32'hFFFFFFFF;
            mif.srcbE  = 32'd2;
            @(negedge clk);
            mif.startE    = 1'b0;
            mif.hiloreadD = (s == 0);
            mif.mdstartD  = (s == 1);
            #1;
            n = 0;
            bad = 0;
            while (mif.busy && n < 100) begin
                n++;
                if (mif.stallmd !== 1'b1) bad++;
                @(negedge clk);
            end
            vecs++;
            if (n != 33 || bad != 0) begin
                errs++; $display("FAIL stall%0d_busy got n=%0d low=%0d want 33 0",
                                 s, n, bad);
            end
            vecs++;
            if (mif.stallmd !== 1'b0) begin
                errs++; $display("FAIL stall%0d_release got %b want 0", s, mif.stallmd);
            end
            vecs++;
            if (mif.hi !== 32'h1 || mif.lo !== 32'hFFFFFFFE) begin
                errs++; $display("FAIL stall%0d_hilo got %h_%h want 00000001_fffffffe",
                                 s, mif.hi, mif.lo);
            end
            mif.hiloreadD = 1'b0;
            mif.mdstartD  = 1'b0;
        end
    endtask

    task automatic test_reset_midop;
        int n; logic dn, early; logic [W-1:0] h, l;
        mif.startE = 1'b1;
        mif.opE    = MD_MULT;
        mif.srcaE  = 32'd123;
        mif.srcbE  = 32'd456;
        @(negedge clk);
        mif.startE = 1'b0;
        repeat (9) @(negedge clk);
        vecs++;
        if (mif.busy !== 1'b1) begin
            errs++; $display("FAIL midop_busy got %b want 1", mif.busy);
        end
        #2 reset = 1'b1;
        #1;
        vecs++;
        if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
            errs++; $display("FAIL midop_rst got busy=%b done=%b want 0 0",
                             mif.busy, mif.done);
        end
        vecs++;
        if (mif.hi !== '0 || mif.lo !== '0) begin
            errs++; $display("FAIL midop_hilo got %h_%h want 0_0", mif.hi, mif.lo);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done !== 1'b0 || mif.busy !== 1'b0) n++;
        end
        vecs++;
        if (n != 0) begin
            errs++; $display("FAIL midop_quiet got %0d active cycles want 0", n);
        end
        do_op(MD_DIVU, 32'd9, 32'd3, n, dn, early, h, l);
        vecs++;
        if (n != 33 || h !== 32'd0 || l !== 32'd3) begin
            errs++; $display("FAIL divu_9_3 got %0d %h_%h want 33 00000000_00000003",
                             n, h, l);
        end
    endtask

    initial begin
        reset         = 1'b1;
        mif.startE    = 1'b0;
        mif.opE       = 2'b00;
        mif.srcaE     = '0;
        mif.srcbE     = '0;
        mif.hiloreadD = 1'b1;
        mif.mdstartD  = 1'b1;
        test_reset;
        test_mult;
        test_mult_extremes;
        test_div;
        test_div_zero;
        test_stall;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the Execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU from Execute and sequences a shift-add multiplier or restoring divider over WIDTH cycles. It raises a stall request toward the hazard logic while a Decode-stage instruction needs HI/LO or the unit itself.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
startE  in  1  valid mult/div in Execute; already qualified by the pipeline (not flushed, not stalled)
opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcaE  in  WIDTH  rs operand: multiplicand or dividend
srcbE  in  WIDTH  rt operand: multiplier or divisor
hiloreadD  in  1  Decode instruction is MFHI/MFLO
mdstartD  in  1  Decode instruction is MULT/MULTU/DIV/DIVU
stallmd  out  1  stall request to hazard unit
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, counter=0, internal accumulators=0, done=0. An in-flight operation is discarded and HI/LO are not updated.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, startE=1: latch |srcaE| and |srcbE| as magnitudes; signed ops only (MULT/DIV) negate a negative operand. Latch the sign flags and op, clear counter. Next state is MUL or DIV.
- DIV with srcbE==0: skip to FIXUP with the div-by-zero flag set.
- MUL: each cycle, add the multiplicand to the upper half if product LSB=1, then shift the 2*WIDTH-bit product right by 1 with carry-in. counter++. After WIDTH iterations go to FIXUP.
- DIV: restoring step each cycle. Shift {rem,quot} left 1, trial-subtract the divisor from rem, keep the result if non-negative and set the quotient LSB. counter++. After WIDTH iterations go to FIXUP.
- FIXUP, MULT: if the sign flags differ, take the two's complement of the 2*WIDTH product. hi=product[2W-1:W], lo=product[W-1:0].
- FIXUP, DIV: quotient is negated if the signs differ; remainder takes the dividend's sign. lo=quotient, hi=remainder.
- FIXUP, div-by-zero: lo=all ones, hi=srcaE as latched (original, not magnitude).
- FIXUP always goes to IDLE. HI/LO are written on the FIXUP→IDLE edge. done is registered high for exactly the following cycle.
- Latency: start sampled at edge E0. busy=1 for WIDTH+1 cycles (WIDTH+0... for div-by-zero: 1 cycle FIXUP only, busy=1 for 1 cycle). HI/LO are valid in the first cycle busy=0.
- busy = (state != IDLE). Counter width = $clog2(WIDTH)+1. No arithmetic overflow is flagged; the most-negative/-1 divide yields lo=0x80000000, hi=0 via normal fixup.
- stallmd = busy & (hiloreadD | mdstartD), combinational. hi/lo outputs are registered and never show partial results.
- startE while busy: illegal (stallmd prevents it). RTL ignores it and the bench asserts it never occurs.
- startE in the same cycle as done: accepted normally (state is IDLE).

Decomposition:
- mdu_pkg: op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum (IDLE, MUL, DIV, FIXUP), funct constants 0x18–0x1B, 0x10, 0x12.
- One sub-module: mdu_step, a combinational single iteration (shift-add or restoring-subtract selected by mode). The FSM, counter, and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULT 7 × -3 (0x00000007, 0xFFFFFFFD) → busy 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT on the same operands → hi=0, lo=1.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- DIVU 5 / 0 → busy exactly 1 cycle, lo=0xFFFFFFFF, hi=0x00000005.
- hiloreadD held high from the cycle after start → stallmd=1 for all busy cycles, 0 in the first cycle busy=0. mdstartD behaves the same. stallmd=0 when idle.
- Reset asserted asynchronously at iteration 10 of a MULT → busy=0, hi=lo=0 immediately, no done. A new DIVU 9/3 afterwards → lo=3, hi=0.
